tone_accum_sched: RTL and testbench

//  Time-multiplexes one shared W-bit full_adder across VOICES phase accumulators.

---
 rtl/tone_accum_sched_pkg.sv | 13 +
 rtl/tone_accum_sched_if.sv | 29 ++
 rtl/full_adder.sv | 14 +
 rtl/tone_accum_sched.sv | 110 +++++++++++
 tb/tb_tone_accum_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_accum_sched_pkg.sv
// Shared definitions for the tone accumulator scheduler: FSM encoding and default sizing.
package tone_accum_sched_pkg;

    localparam int W_DEF      = 22;
    localparam int VOICES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tone_accum_sched_if.sv
// Control/config/status bundle between the note logic (master) and the scheduler (slave).
interface tone_accum_sched_if #(
    parameter int W      = tone_accum_sched_pkg::W_DEF,
    parameter int VOICES = tone_accum_sched_pkg::VOICES_DEF
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic              tick;
    logic              cfg_we;
    logic [VW-1:0]     cfg_voice;
    logic [W-1:0]      cfg_inc;
    logic              cfg_en;
    logic              ovr_clr;
    logic              busy;
    logic              sample_done;
    logic              overrun;
    logic [VOICES-1:0] tone_out;

    modport master (
        output tick, cfg_we, cfg_voice, cfg_inc, cfg_en, ovr_clr,
        input  busy, sample_done, overrun, tone_out
    );

    modport slave (
        input  tick, cfg_we, cfg_voice, cfg_inc, cfg_en, ovr_clr,
        output busy, sample_done, overrun, tone_out
    );

endinterface

// File: rtl/full_adder.sv
// n-bit ripple-style adder with carry in/out; the single adder shared by all voices.
module full_adder #(
    parameter int n = 22
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         ci,
    output logic [n-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, ci};

endmodule

// File: rtl/tone_accum_sched.sv
// Round-robin phase accumulation for VOICES tone generators over one shared adder.
//
//  state | meaning
//  IDLE  | waiting for a sample tick
//  ACCUM | adding inc[idx] into phase[idx], one voice per clock
//  DONE  | all voices updated; sample_done asserted for this cycle
module tone_accum_sched
    import tone_accum_sched_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int VOICES = VOICES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    tone_accum_sched_if.slave bus
);

    localparam int            VW   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

    state_t            state_q, state_d;
    logic [VW-1:0]     idx_q, idx_d;
    logic [W-1:0]      phase [VOICES];
    logic [W-1:0]      inc   [VOICES];
    logic [VOICES-1:0] en;
    logic [VOICES-1:0] tone_q;
    logic              busy_q, done_q, ovr_q;
    logic [W-1:0]      sum;
    logic              co;
    logic              dropped;

    full_adder #(.n(W)) u_add (
        .a  (phase[idx_q]),
        .b  (inc[idx_q]),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                end
            end
            ACCUM: begin
                if (idx_q == LAST) state_d = DONE;
                else               idx_d   = idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dropped = bus.tick && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            // a dropped tick outranks a simultaneous clear
            if (dropped)          ovr_q <= 1'b1;
            else if (bus.ovr_clr) ovr_q <= 1'b0;
        end
    end

    // adder operands come from the registers as they stood before any same-edge cfg write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
            end
            en     <= '0;
            tone_q <= '0;
        end else begin
            if (state_q == ACCUM) begin
                if (en[idx_q]) begin
                    phase[idx_q] <= sum;
                    if (co) tone_q[idx_q] <= ~tone_q[idx_q];
                end else begin
                    phase[idx_q]  <= '0;
                    tone_q[idx_q] <= 1'b0;
                end
            end
            if (bus.cfg_we) begin
                inc[bus.cfg_voice] <= bus.cfg_inc;
                en[bus.cfg_voice]  <= bus.cfg_en;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.sample_done = done_q;
    assign bus.overrun     = ovr_q;
    assign bus.tone_out    = tone_q;

endmodule

// File: tb/tb_tone_accum_sched.sv
// Self-checking bench: control-timing vector table, directed phase/tone sequences, random run vs. model.
module tb_tone_accum_sched;

    localparam int W      = 22;
    localparam int VOICES = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    tone_accum_sched_if #(.W(W), .VOICES(VOICES)) bus ();

    tone_accum_sched #(.W(W), .VOICES(VOICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: per-voice phase/inc/en/tone plus a slot number for the pass in flight
    // (-1 idle, 0..VOICES-1 voice added at the next edge, VOICES done cycle).
    logic [W-1:0]      m_phase [VOICES];
    logic [W-1:0]      m_inc   [VOICES];
    logic [VOICES-1:0] m_en;
    logic [VOICES-1:0] m_tone;
    logic              m_ovr;
    int                m_slot;

    typedef struct {
        logic rst;
        logic tick;
        logic clr;
        logic busy;
        logic done;
        logic ovr;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [W:0] t;
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                m_phase[v] = '0;
                m_inc[v]   = '0;
            end
            m_en   = '0;
            m_tone = '0;
            m_ovr  = 1'b0;
            m_slot = -1;
        end else begin
            if (bus.tick && m_slot >= 0) m_ovr = 1'b1;
            else if (bus.ovr_clr)        m_ovr = 1'b0;
            if (m_slot >= 0 && m_slot < VOICES) begin
                if (m_en[m_slot]) begin
                    t = {1'b0, m_phase[m_slot]} + {1'b0, m_inc[m_slot]};
                    m_phase[m_slot] = t[W-1:0];
                    if (t[W]) m_tone[m_slot] = ~m_tone[m_slot];
                end else begin
                    m_phase[m_slot] = '0;
                    m_tone[m_slot]  = 1'b0;
                end
            end
            if (bus.cfg_we) begin
                m_inc[bus.cfg_voice] = bus.cfg_inc;
                m_en[bus.cfg_voice]  = bus.cfg_en;
            end
            if (m_slot < 0)            m_slot = bus.tick ? 0 : -1;
            else if (m_slot == VOICES) m_slot = -1;
            else                       m_slot = m_slot + 1;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("outputs", {25'd0, bus.busy, bus.sample_done, bus.overrun, bus.tone_out},
              {25'd0, (m_slot >= 0), (m_slot == VOICES), m_ovr, m_tone});
        for (int v = 0; v < VOICES; v++)
            check($sformatf("phase%0d", v), 32'(dut.phase[v]), 32'(m_phase[v]));
    endtask

    task automatic idle_in();
        rst           = 1'b0;
        bus.tick      = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_voice = '0;
        bus.cfg_inc   = '0;
        bus.cfg_en    = 1'b0;
        bus.ovr_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic cfg(input int v, input logic [W-1:0] inc_v, input logic en_v);
        bus.cfg_we    = 1'b1;
        bus.cfg_voice = 2'(v);
        bus.cfg_inc   = inc_v;
        bus.cfg_en    = en_v;
        cyc();
        bus.cfg_we = 1'b0;
    endtask

    task automatic run_pass();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        repeat (VOICES + 1) cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rst tick clr | busy done ovr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle_in();
        for (int i = 0; i < 22; i++) begin
            idle_in();
            rst         = tbl[i].rst;
            bus.tick    = tbl[i].tick;
            bus.ovr_clr = tbl[i].clr;
            cyc();
            check($sformatf("tbl%0d", i), {29'd0, bus.busy, bus.sample_done, bus.overrun},
                  {29'd0, tbl[i].busy, tbl[i].done, tbl[i].ovr});
            if (i == 0) check("reset_tone", 32'(bus.tone_out), 32'd0);
        end
        idle_in();

        // voice 0 wraps every 4th pass
        do_reset();
        cfg(0, 22'h100000, 1'b1);
        for (int p = 1; p <= 8; p++) begin
            run_pass();
            if (p == 3) check("v0_tone_p3", 32'(bus.tone_out[0]), 32'd0);
            if (p == 4) begin
                check("v0_tone_p4", 32'(bus.tone_out[0]), 32'd1);
                check("v0_phase_p4", 32'(dut.phase[0]), 32'd0);
            end
            if (p == 8) begin
                check("v0_tone_p8", 32'(bus.tone_out[0]), 32'd0);
                check("v0_phase_p8", 32'(dut.phase[0]), 32'd0);
            end
        end

        // near-full-scale increment on voice 1
        cfg(1, 22'h3FFFFF, 1'b1);
        run_pass();
        check("v1_phase_a", 32'(dut.phase[1]), 32'h3FFFFF);
        check("v1_tone_a", 32'(bus.tone_out[1]), 32'd0);
        run_pass();
        check("v1_phase_b", 32'(dut.phase[1]), 32'h3FFFFE);
        check("v1_tone_b", 32'(bus.tone_out[1]), 32'd1);

        // write to voice 2 in its own add slot, then disable voice 0
        do_reset();
        cfg(0, 22'h300000, 1'b1);
        cfg(2, 22'h000010, 1'b1);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        cyc();
        cfg(2, 22'h000020, 1'b1);
        cyc();
        cyc();
        check("v2_phase_a", 32'(dut.phase[2]), 32'h10);
        run_pass();
        check("v2_phase_b", 32'(dut.phase[2]), 32'h30);
        check("v0_phase_wrap", 32'(dut.phase[0]), 32'h200000);
        check("v0_tone_wrap", 32'(bus.tone_out[0]), 32'd1);
        cfg(0, 22'h300000, 1'b0);
        run_pass();
        check("v0_phase_off", 32'(dut.phase[0]), 32'd0);
        check("v0_tone_off", 32'(bus.tone_out[0]), 32'd0);
        check("v2_phase_c", 32'(dut.phase[2]), 32'h50);

        // reset in the middle of a pass
        do_reset();
        for (int v = 0; v < VOICES; v++) cfg(v, 22'h1, 1'b1);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        check("mid_v0", 32'(dut.phase[0]), 32'd1);
        check("mid_v2", 32'(dut.phase[2]), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_v3", 32'(dut.phase[3]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            cyc();
            check("mid_rst_no_done", 32'(bus.sample_done), 32'd0);
        end

        // randomized traffic against the model
        do_reset();
        for (int v = 0; v < VOICES; v++) cfg(v, W'($urandom), 1'b1);
        for (int c = 0; c < 800; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.tick      = ($urandom_range(0, 3) == 0);
            bus.cfg_we    = ($urandom_range(0, 5) == 0);
            bus.cfg_voice = 2'($urandom_range(0, VOICES - 1));
            bus.cfg_inc   = W'($urandom);
            bus.cfg_en    = ($urandom_range(0, 4) != 0);
            bus.ovr_clr   = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle_in();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
